// File: rtl/mips16_pkg.sv
// Shared constants and types for the MIPS-16 datapath: widths, link register
// index, the hardwired-zero register index and the clear sequencer states.
package mips16_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int RA_IDX = 7;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = reg_idx_t'(0);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } seq_state_t;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks clr_idx from 1 to the last entry, one
// entry per edge, holding busy high until the whole file has been zeroed.
module regfile_clear_seq #(
    parameter int ADDR_W = mips16_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);
    import mips16_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    seq_state_t        state, state_nxt;
    logic [ADDR_W-1:0] idx_nxt;
    logic              busy_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= ADDR_W'(1);
            busy    <= 1'b1;
        end else begin
            state   <= state_nxt;
            clr_idx <= idx_nxt;
            busy    <= busy_nxt;
        end
    end

    // The counter holds at the terminal index instead of wrapping.
    always_comb begin
        state_nxt = state;
        idx_nxt   = clr_idx;
        busy_nxt  = busy;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = !reset;
                if (clr_idx == LAST_IDX) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    idx_nxt = clr_idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_16.sv
// Eight-entry register file with combinational reads, link-over-writeback
// write priority and a post-reset clear. Optional macro: REGFILE_BYPASS_EN.
module regfile_16 #(
    parameter int DATA_W = mips16_pkg::DATA_W,
    parameter int ADDR_W = mips16_pkg::ADDR_W,
    parameter int RA_IDX = mips16_pkg::RA_IDX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              link_en,
    input  logic [DATA_W-1:0] link_pc,
    output logic              busy
);
    import mips16_pkg::*;

    localparam logic [ADDR_W-1:0] RA = ADDR_W'(RA_IDX);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_acc;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_val;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .reset   (reset),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    // Link wins over write-back; writes aimed at register 0 are never accepted.
    always_comb begin
        wr_idx = wr_addr;
        wr_val = wr_data;
        if (link_en) begin
            wr_idx = RA;
            wr_val = link_pc;
        end
        wr_acc = !reset && !busy && (link_en || we) && (wr_idx != REG_ZERO);
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_acc) begin
            mem[wr_idx] <= wr_val;
        end
    end

    always_comb begin
        rs_data = '0;
        if (!busy && rs_addr != REG_ZERO) begin
            rs_data = mem[rs_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_acc && wr_idx == rs_addr) rs_data = wr_val;
`endif
        end
    end

    always_comb begin
        rt_data = '0;
        if (!busy && rt_addr != REG_ZERO) begin
            rt_data = mem[rt_addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_acc && wr_idx == rt_addr) rt_data = wr_val;
`endif
        end
    end

endmodule

// File: tb/tb_regfile_16.sv
// Scoreboard bench for regfile_16: expected read values are queued when the
// stimulus is driven and popped when the read ports are sampled.
module tb_regfile_16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  rs_addr = '0;
    logic [2:0]  rt_addr = '0;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        we = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        link_en = 1'b0;
    logic [15:0] link_pc = '0;
    logic        busy;

    int checks = 0;
    int passed = 0;

    logic [15:0] exp_q [$];
    logic [15:0] e;

    regfile_16 dut (
        .clk     (clk),
        .reset   (reset),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .link_en (link_en),
        .link_pc (link_pc),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; wr_addr = a; wr_data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL reset_busy: got %b required 1", busy);
        else passed++;
        exp_q.push_back(16'h0000);
        rs_addr = 3'd5;
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rs_data !== e) $display("FAIL reset_rs: got %h required %h", rs_data, e);
        else passed++;
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (busy !== (k < 7)) $display("FAIL release_busy_edge%0d: got %b required %b", k, busy, (k < 7));
            else passed++;
        end
        for (int i = 0; i < 8; i++) begin
            rs_addr = 3'(i);
            rt_addr = 3'(7 - i);
            exp_q.push_back(16'h0000);
            exp_q.push_back(16'h0000);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (rs_data !== e) $display("FAIL cleared_rs%0d: got %h required %h", i, rs_data, e);
            else passed++;
            e = exp_q.pop_front();
            checks++;
            if (rt_data !== e) $display("FAIL cleared_rt%0d: got %h required %h", 7 - i, rt_data, e);
            else passed++;
        end
    endtask

    task automatic test_write_read;
        do_write(3'd3, 16'h5BF3);
        do_write(3'd5, 16'h0011);
        rs_addr = 3'd3;
        rt_addr = 3'd5;
        exp_q.push_back(16'h5BF3);
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h5C04);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rs_data !== e) $display("FAIL rd_rs3: got %h required %h", rs_data, e);
        else passed++;
        e = exp_q.pop_front();
        checks++;
        if (rt_data !== e) $display("FAIL rd_rt5: got %h required %h", rt_data, e);
        else passed++;
        e = exp_q.pop_front();
        checks++;
        if (16'(rs_data + rt_data) !== e) $display("FAIL alu_add: got %h required %h", 16'(rs_data + rt_data), e);
        else passed++;
    endtask

    task automatic test_zero_reg;
        we = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        rt_addr = 3'd0;
        exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rt_data !== e) $display("FAIL zero_same_cycle: got %h required %h", rt_data, e);
        else passed++;
        tick();
        we = 1'b0;
        rs_addr = 3'd0;
        exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rs_data !== e) $display("FAIL zero_after: got %h required %h", rs_data, e);
        else passed++;
    endtask

    task automatic test_link_priority;
        link_en = 1'b1; link_pc = 16'h0042;
        we = 1'b1; wr_addr = 3'd7; wr_data = 16'h1234;
        tick();
        link_en = 1'b0; we = 1'b0;
        rs_addr = 3'd7;
        rt_addr = 3'd3;
        exp_q.push_back(16'h0042);
        exp_q.push_back(16'h5BF3);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rs_data !== e) $display("FAIL link_rs7: got %h required %h", rs_data, e);
        else passed++;
        e = exp_q.pop_front();
        checks++;
        if (rt_data !== e) $display("FAIL link_rt3: got %h required %h", rt_data, e);
        else passed++;
    endtask

    task automatic test_bypass;
        do_write(3'd4, 16'h1111);
        we = 1'b1; wr_addr = 3'd4; wr_data = 16'h2ABF;
        rs_addr = 3'd4;
        rt_addr = 3'd4;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(16'h2ABF);
`else
        exp_q.push_back(16'h1111);
`endif
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rs_data !== e) $display("FAIL bypass_same_cycle: got %h required %h", rs_data, e);
        else passed++;
        tick();
        we = 1'b0;
        exp_q.push_back(16'h2ABF);
        exp_q.push_back(16'h2ABF);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rs_data !== e) $display("FAIL bypass_next_rs: got %h required %h", rs_data, e);
        else passed++;
        e = exp_q.pop_front();
        checks++;
        if (rt_data !== e) $display("FAIL bypass_next_rt: got %h required %h", rt_data, e);
        else passed++;
    endtask

    task automatic test_busy_edge_write;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        we = 1'b1; wr_addr = 3'd2; wr_data = 16'hAF23;
        tick();
        we = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL busy_edge7: got %b required 0", busy);
        else passed++;
        rs_addr = 3'd2;
        exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rs_data !== e) $display("FAIL busy_write_dropped: got %h required %h", rs_data, e);
        else passed++;
        do_write(3'd2, 16'hAF23);
        exp_q.push_back(16'hAF23);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rs_data !== e) $display("FAIL edge8_write: got %h required %h", rs_data, e);
        else passed++;
    endtask

    task automatic test_reset_mid_clear;
        do_write(3'd6, 16'hBEEF);
        rs_addr = 3'd6;
        exp_q.push_back(16'hBEEF);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rs_data !== e) $display("FAIL pre_reg6: got %h required %h", rs_data, e);
        else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL restart_busy: got %b required 1", busy);
        else passed++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (busy !== (k < 7)) $display("FAIL restart_busy_edge%0d: got %b required %b", k, busy, (k < 7));
            else passed++;
        end
        exp_q.push_back(16'h0000);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rs_data !== e) $display("FAIL reg6_cleared: got %h required %h", rs_data, e);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_link_priority();
        test_bypass();
        test_busy_edge_write();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
